ram_rr_arbiter: RTL and testbench

RAM_RR_ARBITER -- requirements
Module: ram_rr_arbiter

---
 rtl/ram_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_ram_rr_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_rr_arbiter
// Description : Round-robin arbiter granting NUM_REQ requesters access to one
//               internal simple dual-port RAM, with a 2-stage read pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]  rsp_data,
    output logic [15:0]                    grant_count
);

    localparam int                   c_ptr_w = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int                   c_depth = 2 ** ADDR_WIDTH;
    localparam logic [c_ptr_w:0]     c_num   = NUM_REQ[c_ptr_w:0];
    localparam logic [c_ptr_w-1:0]   c_last  = c_ptr_w'(NUM_REQ - 1);

    logic [c_ptr_w-1:0]     r_ptr;
    logic [15:0]            r_count;
    logic [NUM_REQ-1:0]     w_grant;
    logic [c_ptr_w-1:0]     w_gidx;
    logic [c_ptr_w:0]       w_sum;
    logic                   w_accept;
    logic                   w_we;
    logic [ADDR_WIDTH-1:0]  w_addr;
    logic [DATA_WIDTH-1:0]  w_wdata;

    logic [DATA_WIDTH-1:0]  r_mem [c_depth];
    logic                   r_s1_valid;
    logic [c_ptr_w-1:0]     r_s1_idx;
    logic [DATA_WIDTH-1:0]  r_s1_data;
    logic [NUM_REQ-1:0]     r_rsp_valid;
    logic [DATA_WIDTH-1:0]  r_rsp_data [NUM_REQ];

    // Search from the pointer upward with wrap; the first valid requester wins.
    always_comb begin
        w_grant  = '0;
        w_gidx   = '0;
        w_sum    = '0;
        w_accept = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + k[c_ptr_w:0];
            if (w_sum >= c_num) begin
                w_sum = w_sum - c_num;
            end
            if (!w_accept && req_valid[w_sum]) begin
                w_accept = 1'b1;
                w_gidx   = w_sum[c_ptr_w-1:0];
            end
        end
        if (rst) begin
            w_accept = 1'b0;
        end
        if (w_accept) begin
            w_grant[w_gidx] = 1'b1;
        end
    end

    assign req_ready   = w_grant;
    assign w_we        = req_we[w_gidx];
    assign w_addr      = req_addr[int'(w_gidx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata     = req_wdata[int'(w_gidx)*DATA_WIDTH +: DATA_WIDTH];
    assign grant_count = r_count;
    assign rsp_valid   = r_rsp_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_count    <= '0;
            r_s1_valid <= 1'b0;
            r_s1_idx   <= '0;
        end else begin
            r_s1_valid <= w_accept && !w_we;
            r_s1_idx   <= w_gidx;
            if (w_accept) begin
                r_ptr   <= (w_gidx == c_last) ? '0 : w_gidx + 1'b1;
                r_count <= r_count + 16'd1;
            end
        end
    end

    // RAM array and its read register carry no reset; only the valid bits do.
    always_ff @(posedge clk) begin
        if (w_accept && w_we) begin
            r_mem[w_addr] <= w_wdata;
        end
        if (w_accept && !w_we) begin
            r_s1_data <= r_mem[w_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_rsp_data[i] <= '0;
            end
        end else begin
            r_rsp_valid <= '0;
            if (r_s1_valid) begin
                r_rsp_valid[r_s1_idx] <= 1'b1;
                r_rsp_data[r_s1_idx]  <= r_s1_data;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp_pack
            assign rsp_data[g*DATA_WIDTH +: DATA_WIDTH] = r_rsp_data[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_rr_arbiter
// Description : Directed self-checking bench for ram_rr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_we;
    logic [35:0] req_addr;
    logic [79:0] req_wdata;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [79:0] rsp_data;
    logic [15:0] grant_count;

    int n_checks;
    int n_errors;
    logic [19:0] r_wmem [4];

    ram_rr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (20),
        .ADDR_WIDTH (9)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .grant_count (grant_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clr_req();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [8:0] a, input logic [19:0] d);
        req_valid[i]         = 1'b1;
        req_we[i]            = we;
        req_addr[i*9 +: 9]   = a;
        req_wdata[i*20 +: 20] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_req();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_rdy;
        logic [3:0] exp_rv;
        logic [3:0] vbits;
        int mp;
        int gap;
        int maxgap;
        int idx;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        clr_req();
        for (int i = 0; i < 4; i++) begin
            r_wmem[i] = 20'hA0000 + 20'(i) * 20'h01111;
        end

        // Reset state, with all requesters asking during reset.
        tick();
        req_valid = 4'hF;
        settle();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_rspv", 32'(rsp_valid), 32'h0);
        chk("rst_count", 32'(grant_count), 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("rst_rdata", 32'(rsp_data[i*20 +: 20]), 32'h0);
        end
        tick();
        rst = 1'b0;
        clr_req();
        settle();
        chk("idle_ready", 32'(req_ready), 32'h0);

        // Preload four words through requester 0.
        for (int i = 0; i < 4; i++) begin
            tick();
            clr_req();
            set_req(0, 1'b1, 9'(16 + i), r_wmem[i]);
            settle();
            chk("pre_ready", 32'(req_ready), 32'h1);
        end
        tick();
        clr_req();
        settle();
        chk("pre_count", 32'(grant_count), 32'd4);

        // All four read for 8 cycles: rotation 0..3 twice, responses 2 cycles later.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            tick();
            clr_req();
            if (c < 8) begin
                for (int i = 0; i < 4; i++) set_req(i, 1'b0, 9'(16 + i), 20'h0);
            end
            settle();
            exp_rdy = (c < 8) ? 4'(1 << (c % 4)) : 4'h0;
            exp_rv  = (c >= 2) ? 4'(1 << ((c - 2) % 4)) : 4'h0;
            chk("rr_ready", 32'(req_ready), 32'(exp_rdy));
            chk("rr_rspv", 32'(rsp_valid), 32'(exp_rv));
            if (c >= 2) begin
                idx = (c - 2) % 4;
                chk("rr_rdata", 32'(rsp_data[idx*20 +: 20]), 32'(r_wmem[idx]));
            end
        end
        chk("rr_count", 32'(grant_count), 32'd8);

        // Write by 2 then read-after-write by 1 on the next cycle.
        tick();
        clr_req();
        set_req(2, 1'b1, 9'h05, 20'hABCDE);
        settle();
        chk("raw_wr_ready", 32'(req_ready), 32'h4);
        tick();
        clr_req();
        set_req(1, 1'b0, 9'h05, 20'h0);
        settle();
        chk("raw_rd_ready", 32'(req_ready), 32'h2);
        tick();
        clr_req();
        settle();
        chk("raw_rspv_t2", 32'(rsp_valid), 32'h0);
        tick();
        settle();
        chk("raw_rspv_t3", 32'(rsp_valid), 32'h2);
        chk("raw_rdata", 32'(rsp_data[20 +: 20]), 32'hABCDE);
        chk("raw_count", 32'(grant_count), 32'd10);

        // Pointer wrap 3 -> 0, then idle holds pointer and count.
        tick();
        clr_req();
        set_req(2, 1'b1, 9'h1F, 20'h1);
        settle();
        chk("wrap_g2", 32'(req_ready), 32'h4);
        tick();
        clr_req();
        set_req(0, 1'b1, 9'h1F, 20'h2);
        set_req(3, 1'b1, 9'h1F, 20'h3);
        settle();
        chk("wrap_g3", 32'(req_ready), 32'h8);
        tick();
        settle();
        chk("wrap_g0", 32'(req_ready), 32'h1);
        tick();
        clr_req();
        settle();
        chk("wrap_none", 32'(req_ready), 32'h0);
        chk("wrap_count", 32'(grant_count), 32'd13);
        tick();
        settle();
        chk("idle_count", 32'(grant_count), 32'd13);
        tick();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 9'h1F, 20'h4);
        settle();
        chk("ptr_held", 32'(req_ready), 32'h2);
        tick();
        clr_req();
        settle();
        chk("ptr_count", 32'(grant_count), 32'd14);

        // Reset one cycle after an accepted read drops the response.
        tick();
        clr_req();
        set_req(3, 1'b0, 9'h10, 20'h0);
        settle();
        chk("drop_acc", 32'(req_ready), 32'h8);
        tick();
        rst = 1'b1;
        req_valid = 4'hF;
        settle();
        chk("drop_rst_ready", 32'(req_ready), 32'h0);
        chk("drop_rspv_t1", 32'(rsp_valid), 32'h0);
        tick();
        rst = 1'b0;
        clr_req();
        settle();
        chk("drop_rspv_t2", 32'(rsp_valid), 32'h0);
        chk("drop_count", 32'(grant_count), 32'h0);
        tick();
        settle();
        chk("drop_rspv_t3", 32'(rsp_valid), 32'h0);
        tick();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 9'h1E, 20'h5);
        settle();
        chk("drop_next_g0", 32'(req_ready), 32'h1);

        // Requester 0 always asking, others varying: fairness against a model.
        mp = 1;
        gap = 0;
        maxgap = 0;
        for (int c = 0; c < 24; c++) begin
            tick();
            clr_req();
            vbits = {3'($urandom_range(0, 7)), 1'b1};
            for (int i = 0; i < 4; i++) begin
                if (vbits[i]) set_req(i, 1'b1, 9'h1E, 20'(c));
            end
            settle();
            exp_rdy = '0;
            for (int k = 0; k < 4; k++) begin
                idx = (mp + k) % 4;
                if (exp_rdy == 4'h0 && vbits[idx]) exp_rdy = 4'(1 << idx);
            end
            chk("fair_grant", 32'(req_ready), 32'(exp_rdy));
            for (int i = 0; i < 4; i++) begin
                if (exp_rdy[i]) mp = (i + 1) % 4;
            end
            if (req_ready[0]) gap = 0;
            else gap++;
            if (gap > maxgap) maxgap = gap;
        end
        chk("fair_maxgap_le3", 32'(maxgap <= 3), 32'h1);

        // Grant counter wrap.
        do_reset();
        for (int n = 0; n < 65535; n++) begin
            tick();
            req_valid = 4'h1;
            req_we    = 4'h1;
        end
        tick();
        clr_req();
        settle();
        chk("cnt_ffff", 32'(grant_count), 32'hFFFF);
        tick();
        req_valid = 4'h1;
        req_we    = 4'h1;
        tick();
        clr_req();
        settle();
        chk("cnt_wrap0", 32'(grant_count), 32'h0);
        tick();
        req_valid = 4'h1;
        req_we    = 4'h1;
        tick();
        clr_req();
        settle();
        chk("cnt_one", 32'(grant_count), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
